// File: rtl/dmem_responder.sv
// Request/ack data-memory responder with byte/half/word access, load extension and misalignment flagging.
// Optional wait states: define DMEM_WAIT_EN to insert WAIT_CYCLES cycles between acceptance and access.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        misalign
);

    localparam int IDX_W    = $clog2(DEPTH_WORDS);
    localparam int ADDR_MSB = IDX_W + 1;

    // state    | meaning
    // S_IDLE   | waiting for req, captures request fields on acceptance
    // S_WAIT   | wait-state countdown (DMEM_WAIT_EN only)
    // S_ACCESS | read/write performed at the leaving edge, ack raised
    // S_RESP   | ack high for this cycle, busy drops at the leaving edge
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
`ifdef DMEM_WAIT_EN
        S_WAIT   = 2'd3,
`endif
        S_RESP   = 2'd2
    } state_t;

    state_t state;

    logic [ADDR_MSB:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_val;
    logic [3:0]       wr_mask;
    logic [31:0]      wr_data;
    logic             mis_c;

    assign word_idx = addr_q[ADDR_MSB:2];
    assign lane     = addr_q[1:0];

`ifdef DMEM_WAIT_EN
    logic [3:0] wait_cnt;
    logic       unused_bits;
    assign unused_bits = ^addr[31:ADDR_MSB+1];
`else
    logic       unused_bits;
    assign unused_bits = ^{addr[31:ADDR_MSB+1], 4'(WAIT_CYCLES)};
`endif

    always_comb begin
        rd_word  = mem[word_idx];
        rd_byte  = rd_word[{lane, 3'b000} +: 8];
        rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        mis_c    = 1'b0;
        load_val = rd_word;
        wr_mask  = 4'b1111;
        wr_data  = wdata_q;
        case (size_q)
            2'b00: begin
                load_val = {{24{~uns_q & rd_byte[7]}}, rd_byte};
                wr_mask  = 4'b0001 << lane;
                wr_data  = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                mis_c    = lane[0];
                load_val = {{16{~uns_q & rd_half[15]}}, rd_half};
                wr_mask  = lane[1] ? 4'b1100 : 4'b0011;
                wr_data  = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                mis_c = (lane != 2'b00);
            end
            default: begin
                mis_c = 1'b1;
            end
        endcase
    end

    // Storage is deliberately not reset; an async reset forces IDLE, which blocks the write.
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && we_q && !mis_c) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            ack      <= 1'b0;
            busy     <= 1'b0;
            misalign <= 1'b0;
            rdata    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
`ifdef DMEM_WAIT_EN
            wait_cnt <= '0;
`endif
        end else begin
            ack      <= 1'b0;
            misalign <= 1'b0;
            rdata    <= '0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        addr_q  <= addr[ADDR_MSB:0];
                        wdata_q <= wdata;
                        size_q  <= size;
                        we_q    <= we;
                        uns_q   <= uns;
                        busy    <= 1'b1;
`ifdef DMEM_WAIT_EN
                        wait_cnt <= 4'(WAIT_CYCLES);
                        state    <= S_WAIT;
`else
                        state   <= S_ACCESS;
`endif
                    end
                end
`ifdef DMEM_WAIT_EN
                S_WAIT: begin
                    if (wait_cnt <= 4'd1) begin
                        wait_cnt <= '0;
                        state    <= S_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
`endif
                S_ACCESS: begin
                    ack      <= 1'b1;
                    misalign <= mis_c;
                    rdata    <= (mis_c || we_q) ? 32'd0 : load_val;
                    state    <= S_RESP;
                end
                S_RESP: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit storage words; must be a power of two.
REQ-002 Parameter WAIT_CYCLES, default 2: extra wait-state cycles per access; used only when DMEM_WAIT_EN is defined; range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  access request level; initiator holds req, we, size, uns, addr and wdata stable until ack.
REQ-006 we  input  1  1 = store, 0 = load.
REQ-007 size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 uns  input  1  load extension: 1 = zero-extend, 0 = sign-extend.
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  32  store data, right-justified: byte in [7:0], half in [15:0].
REQ-011 rdata  output  32  load result, extended to 32 bits; valid only while ack = 1.
REQ-012 ack  output  1  one-cycle completion pulse.
REQ-013 busy  output  1  high from acceptance until ack falls.
REQ-014 misalign  output  1  error flag, qualified by ack.

Function
REQ-015 FSM states: IDLE, WAIT, ACCESS, RESP.
REQ-016 IDLE with req = 1: capture all request fields and set busy = 1 at that edge. Go to ACCESS, or to WAIT if DMEM_WAIT_EN is defined.
REQ-017 ACCESS: perform the read or write at the next edge, then go to RESP.
REQ-018 RESP: ack = 1 for exactly one cycle, then go to IDLE with ack = 0 and busy = 0.
REQ-019 Latency without the macro: ack is high in the cycle after the second edge following acceptance. Minimum spacing between requests is 3 cycles.
REQ-020 req sampled outside IDLE is ignored. A req still high in IDLE after ack is treated as a new request.
REQ-021 Word index is addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-022 Byte store: write wdata[7:0] to lane addr[1:0]. All other lanes are unchanged.
REQ-023 Half store: write wdata[15:0] to lanes {addr[1],1} and {addr[1],0}. Word store writes all four lanes.
REQ-024 Loads select the lane(s) in the same way and extend per uns. rdata = 0 during store ack.
REQ-025 Misaligned access: half with addr[0] = 1, word with addr[1:0] != 0, or size = 11. No storage update; ack still pulses, with misalign = 1 and rdata = 0.
REQ-026 misalign = 0 whenever ack = 0.

Reset
REQ-027 When rst = 0: state = IDLE; ack, busy, misalign, rdata = 0; wait counter = 0. Effect is immediate and does not wait for a clock edge.
REQ-028 Reset during WAIT, ACCESS or RESP aborts the access with no ack. A store aborted before its ACCESS edge leaves storage unchanged.
REQ-029 Storage contents are not cleared by reset.

Configuration
REQ-030 Macro DMEM_WAIT_EN defined: after acceptance, the FSM stays in WAIT for exactly WAIT_CYCLES cycles (down-counter loaded at acceptance), then goes to ACCESS. Ack latency grows by WAIT_CYCLES; busy stays high throughout.
REQ-031 DMEM_WAIT_EN undefined: WAIT state and counter are absent; IDLE goes directly to ACCESS.

Verification
REQ-032 Word path: sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> rdata 0xDEADBEEF, misalign 0, ack exactly one cycle at the REQ-019 latency.
REQ-033 Byte path: sb addr 0x13 data 0x80, then lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lw 0x10 -> 0x80ADBEEF.
REQ-034 Half path: sh addr 0x22 data 0x1234 over word 0xFFFFFFFF at 0x20, then lw 0x20 -> 0x1234FFFF; lh 0x22 -> 0x00001234.
REQ-035 Misaligned: sw addr 0x21 -> ack with misalign 1; subsequent lw 0x20 still returns 0x1234FFFF. lh 0x23 -> misalign 1, rdata 0.
REQ-036 Protocol edges: (a) reset asserted in the ACCESS state of sw 0x30 data 0x55 -> no ack; lw 0x30 returns its prior value. (b) Address 0x410 with DEPTH_WORDS 256 aliases 0x010. (c) req held high -> back-to-back acks spaced 3 cycles apart.
REQ-037 DMEM_WAIT_EN defined, WAIT_CYCLES 3: lw latency grows by exactly 3 cycles; busy stays high until ack; data results match REQ-032.
